weight_streamer: RTL and testbench

WEIGHT_STREAMER -- requirements
Module: weight_streamer

---
 rtl/weight_streamer_pkg.sv | 33 +++
 rtl/weight_rom.sv | 32 +++
 rtl/weight_streamer.sv | 111 +++++++++++
 tb/tb_weight_streamer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_streamer_pkg.sv
// Shared types and derived constants for the FFT twiddle-weight streamer.
package weight_streamer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StFinish = 2'd2
  } state_e;

  localparam real Pi = 3.14159265358979323846;

  // Butterflies per stage for an N = 2**npoint transform.
  function automatic int unsigned calc_h(input int unsigned npoint);
    return 32'd1 << (npoint - 32'd1);
  endfunction

  // Words streamed per sequence: one twiddle per butterfly per stage.
  function automatic int unsigned calc_total(input int unsigned npoint);
    return npoint * calc_h(npoint);
  endfunction

  // Fixed-point value of 1.0 for a word of the given width.
  function automatic int unsigned calc_scale(input int unsigned width);
    return 32'd1 << (width - 32'd2);
  endfunction

  // Round half away from zero.
  function automatic int round_fix(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

endpackage

// File: rtl/weight_rom.sv
// Twiddle table W_N^e for e in 0..H-1, built at elaboration, read combinationally.
module weight_rom
  import weight_streamer_pkg::*;
#(
  parameter int unsigned NPOINT = 3,
  parameter int unsigned WIDTH  = 16
) (
  input  logic        [NPOINT-2:0] e,
  output logic signed [WIDTH-1:0]  w_real,
  output logic signed [WIDTH-1:0]  w_imag
);

  localparam int unsigned H     = calc_h(NPOINT);
  localparam int unsigned N     = 32'd1 << NPOINT;
  localparam real         Scale = real'(calc_scale(WIDTH));

  logic signed [WIDTH-1:0] re_tab [H];
  logic signed [WIDTH-1:0] im_tab [H];

  for (genvar i = 0; i < H; i++) begin : g_tab
    localparam real Ang = 2.0 * Pi * real'(i) / real'(N);
    assign re_tab[i] = WIDTH'(round_fix($cos(Ang) * Scale));
    assign im_tab[i] = WIDTH'(round_fix(-$sin(Ang) * Scale));
  end

  // Table lookup by exponent.
  always_comb begin
    w_real = re_tab[e];
    w_imag = im_tab[e];
  end

endmodule

// File: rtl/weight_streamer.sv
// Streams the per-stage FFT twiddle weights, one registered word per unpaused cycle.
module weight_streamer
  import weight_streamer_pkg::*;
#(
  parameter int unsigned NPOINT = 3,
  parameter int unsigned WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    pause,
  output logic                    busy,
  output logic                    done,
  output logic                    dout_weight_valid,
  output logic signed [WIDTH-1:0] dout_weight_real,
  output logic signed [WIDTH-1:0] dout_weight_imag
);

  localparam int unsigned H     = calc_h(NPOINT);
  localparam int unsigned Total = calc_total(NPOINT);
  localparam int unsigned KW    = $clog2(Total + 1);
  localparam int unsigned EW    = NPOINT - 1;
  localparam logic [KW-1:0] LastK = KW'(Total - 1);

  state_e                  state;
  logic [KW-1:0]           k;
  logic [EW-1:0]           e;
  logic signed [WIDTH-1:0] rom_real;
  logic signed [WIDTH-1:0] rom_imag;
  logic                    emit;
  logic                    last_word;

  weight_rom #(
    .NPOINT(NPOINT),
    .WIDTH (WIDTH)
  ) u_rom (
    .e     (e),
    .w_real(rom_real),
    .w_imag(rom_imag)
  );

  // Exponent of word k: stage s = k/H, butterfly b = k%H, e = (b mod 2**s) << (NPOINT-1-s).
  always_comb begin
    int unsigned kk;
    int unsigned s;
    int unsigned b;
    kk = 32'(k);
    s  = kk / H;
    b  = kk % H;
    e  = EW'((b & ((32'd1 << s) - 32'd1)) << (EW - s));
  end

  // A word leaves on this edge; k is held at 0 in idle so the first word is emitted on the
  // same edge that samples start, keeping back-to-back sequences one cycle apart.
  always_comb begin
    emit      = ((state == StLoad) || ((state == StIdle) && start)) && !pause;
    last_word = (k == LastK);
  end

  // Sequencer: state, word counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= StIdle;
      k                 <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      dout_weight_valid <= 1'b0;
      dout_weight_real  <= '0;
      dout_weight_imag  <= '0;
    end else begin
      done              <= 1'b0;
      dout_weight_valid <= 1'b0;
      if (emit) begin
        dout_weight_valid <= 1'b1;
        dout_weight_real  <= rom_real;
        dout_weight_imag  <= rom_imag;
      end
      unique case (state)
        StIdle: begin
          busy <= start;
          if (start) begin
            if (emit && last_word) begin
              state <= StFinish;
              k     <= '0;
            end else begin
              state <= StLoad;
              k     <= emit ? KW'(1) : '0;
            end
          end
        end
        StLoad: begin
          if (emit) begin
            if (last_word) begin
              state <= StFinish;
              k     <= '0;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        StFinish: begin
          done  <= 1'b1;
          busy  <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_streamer.sv
// Directed bench for weight_streamer with a word scoreboard and shift-register image model.
module tb_weight_streamer;

  localparam int unsigned Npoint = 3;
  localparam int unsigned Width  = 16;
  localparam int unsigned Total  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic busy;
  logic done;
  logic dout_weight_valid;
  logic signed [Width-1:0] dout_weight_real;
  logic signed [Width-1:0] dout_weight_imag;

  typedef struct {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } word_t;

  word_t exp_q[$];
  word_t sr [Total];
  int    e_seq [Total] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int    tw_re [4]     = '{16384, 11585, 0, -11585};
  int    tw_im [4]     = '{0, -11585, -16384, -11585};

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_done = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int done_cyc = 0;
  int done_before;
  logic signed [31:0] last_re = 0;
  logic signed [31:0] last_im = 0;
  bit v_tr[$];
  bit d_tr[$];

  weight_streamer #(
    .NPOINT(Npoint),
    .WIDTH (Width)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .pause            (pause),
    .busy             (busy),
    .done             (done),
    .dout_weight_valid(dout_weight_valid),
    .dout_weight_real (dout_weight_real),
    .dout_weight_imag (dout_weight_imag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_seq();
    for (int j = 0; j < Total; j++) begin
      word_t w;
      w.re = tw_re[e_seq[j]];
      w.im = tw_im[e_seq[j]];
      exp_q.push_back(w);
    end
  endtask

  task automatic new_seq();
    n_valid = 0;
    n_done  = 0;
    for (int j = 0; j < Total; j++) begin
      sr[j].re = 0;
      sr[j].im = 0;
    end
  endtask

  // Sample outputs on the falling edge and score them.
  task automatic check_outputs();
    if (rst_n) begin
      if (dout_weight_valid === 1'b1) begin
        n_valid++;
        last_valid_cyc = cyc;
        chk("busy_with_valid", 32'(busy), 1);
        chk("done_with_valid", 32'(done), 0);
        if (exp_q.size() == 0) begin
          chk("scoreboard_depth", 0, 1);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_real", 32'(dout_weight_real), w.re);
          chk("word_imag", 32'(dout_weight_imag), w.im);
        end
        for (int j = Total - 1; j > 0; j--) sr[j] = sr[j-1];
        sr[0].re = 32'(dout_weight_real);
        sr[0].im = 32'(dout_weight_imag);
        last_re = 32'(dout_weight_real);
        last_im = 32'(dout_weight_imag);
      end else begin
        chk("hold_real", 32'(dout_weight_real), last_re);
        chk("hold_imag", 32'(dout_weight_imag), last_im);
      end
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
        chk("busy_with_done", 32'(busy), 1);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic run_until_done(input int max_cycles);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_within_budget", 32'(got), 1);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 40; i++) begin
      if (n_valid >= n) break;
      step();
    end
    chk("words_reached", n_valid, n);
  endtask

  task automatic check_image();
    for (int j = 0; j < Total; j++) begin
      chk("image_real", sr[Total-1-j].re, tw_re[e_seq[j]]);
      chk("image_imag", sr[Total-1-j].im, tw_im[e_seq[j]]);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(dout_weight_valid), 0);
    chk("rst_real", 32'(dout_weight_real), 0);
    chk("rst_imag", 32'(dout_weight_imag), 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic sequence: one-cycle start, no pause
    new_seq();
    start = 1'b1;
    push_seq();
    step();
    chk("first_valid_latency", 32'(dout_weight_valid), 1);
    start = 1'b0;
    run_until_done(40);
    chk("basic_count", n_valid, Total);
    chk("basic_done_count", n_done, 1);
    chk("done_after_last", done_cyc, last_valid_cyc + 1);
    step();
    chk("basic_idle_busy", 32'(busy), 0);
    chk("basic_idle_done", 32'(done), 0);
    chk("basic_queue_empty", exp_q.size(), 0);
    check_image();

    // Pause for three cycles after word 5
    new_seq();
    start = 1'b1;
    push_seq();
    step();
    start = 1'b0;
    wait_words(6);
    pause = 1'b1;
    repeat (3) step();
    chk("pause_no_words", n_valid, 6);
    chk("pause_busy", 32'(busy), 1);
    pause = 1'b0;
    run_until_done(40);
    chk("pause_count", n_valid, Total);
    chk("pause_done_count", n_done, 1);
    step();

    // Second start mid-sequence is ignored
    new_seq();
    start = 1'b1;
    push_seq();
    step();
    start = 1'b0;
    wait_words(4);
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(40);
    chk("restart_count", n_valid, Total);
    repeat (3) step();
    chk("restart_done_count", n_done, 1);
    chk("restart_queue_empty", exp_q.size(), 0);

    // Reset at word 7 aborts the sequence
    new_seq();
    start = 1'b1;
    push_seq();
    step();
    start = 1'b0;
    wait_words(7);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(dout_weight_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_real", 32'(dout_weight_real), 0);
    chk("abort_imag", 32'(dout_weight_imag), 0);
    exp_q.delete();
    last_re = 0;
    last_im = 0;
    step();
    step();
    rst_n = 1'b1;
    done_before = n_done;
    repeat (3) step();
    chk("abort_no_done", n_done, done_before);
    new_seq();
    start = 1'b1;
    push_seq();
    step();
    start = 1'b0;
    run_until_done(40);
    chk("after_abort_count", n_valid, Total);
    check_image();
    step();

    // start held high: back-to-back sequences one FINISH cycle apart
    new_seq();
    start = 1'b1;
    push_seq();
    push_seq();
    for (int i = 0; i < 60; i++) begin
      step();
      v_tr.push_back(dout_weight_valid);
      d_tr.push_back(done);
      if (n_done == 2) break;
    end
    start = 1'b0;
    chk("held_count", n_valid, 2 * Total);
    chk("held_done_count", n_done, 2);
    chk("held_gap_valid", 32'(v_tr[12]), 0);
    chk("held_gap_done", 32'(d_tr[12]), 1);
    chk("held_second_start", 32'(v_tr[13]), 1);
    chk("held_second_done", 32'(d_tr[25]), 1);
    step();
    chk("held_idle_busy", 32'(busy), 0);
    chk("held_queue_empty", exp_q.size(), 0);

    // start and pause together in idle
    new_seq();
    start = 1'b1;
    pause = 1'b1;
    push_seq();
    step();
    chk("sp_valid", 32'(dout_weight_valid), 0);
    chk("sp_busy", 32'(busy), 1);
    start = 1'b0;
    step();
    chk("sp_still_paused", 32'(dout_weight_valid), 0);
    pause = 1'b0;
    step();
    chk("sp_first_word", 32'(dout_weight_valid), 1);
    run_until_done(40);
    chk("sp_count", n_valid, Total);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
